// File: rtl/fft_frame_ctrl.sv
// Streaming sequencer around an 8-point parallel FFT core: gathers 8 samples,
// pulses write/start, waits for the core (with timeout), then streams 8 bins out.
module fft_frame_ctrl #(
  parameter int DW             = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_real,
  input  logic [DW-1:0]     s_imag,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_real,
  output logic [DW-1:0]     m_imag,
  output logic [2:0]        m_index,
  output logic              m_last,
  output logic              fft_write,
  output logic              fft_start,
  output logic [8*DW-1:0]   fft_in_real,
  output logic [8*DW-1:0]   fft_in_imag,
  input  logic              fft_ready,
  input  logic [8*DW-1:0]   fft_out_real,
  input  logic [8*DW-1:0]   fft_out_imag,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        cnt_r;
  logic [2:0]        idx_r;
  logic              armed_r;
  logic [TW-1:0]     tcnt_r;
  logic [8*DW-1:0]   in_real_r, in_imag_r;
  logic [8*DW-1:0]   out_real_r, out_imag_r;
  logic              timeout_err_r;
  logic [CNT_W-1:0]  frame_count_r;

  logic accept_s, capture_s, timeout_s, beat_s;

  assign accept_s  = (state_r == ST_FILL) && s_valid;
  // armed_r blocks a done level left over from the previous frame
  assign capture_s = (state_r == ST_WAIT) && armed_r && fft_ready;
  assign timeout_s = (state_r == ST_WAIT) && !capture_s && (tcnt_r == TO_LAST);
  assign beat_s    = (state_r == ST_UNLOAD) && m_ready;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (accept_s && (cnt_r == 3'd7)) state_s = ST_LOAD;
        else                             state_s = ST_FILL;
      end
      ST_LOAD:  state_s = ST_START;
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (capture_s)      state_s = ST_UNLOAD;
        else if (timeout_s) state_s = ST_FILL;
        else                state_s = ST_WAIT;
      end
      ST_UNLOAD: begin
        if (beat_s && (idx_r == 3'd7)) state_s = ST_FILL;
        else                           state_s = ST_UNLOAD;
      end
      default: state_s = ST_FILL;
    endcase
  end

  // State register, sample/bin buffers and counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= ST_FILL;
      cnt_r         <= 3'd0;
      idx_r         <= 3'd0;
      armed_r       <= 1'b0;
      tcnt_r        <= {TW{1'b0}};
      in_real_r     <= {(8*DW){1'b0}};
      in_imag_r     <= {(8*DW){1'b0}};
      out_real_r    <= {(8*DW){1'b0}};
      out_imag_r    <= {(8*DW){1'b0}};
      timeout_err_r <= 1'b0;
      frame_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        cnt_r <= cnt_r + 3'd1;  // wraps to 0 on the 8th beat
        for (int k = 0; k < 8; k++) begin
          if (cnt_r == 3'(k)) begin
            in_real_r[k*DW +: DW] <= s_real;
            in_imag_r[k*DW +: DW] <= s_imag;
          end
        end
      end
      if (state_r == ST_START) begin
        armed_r <= 1'b0;
        tcnt_r  <= {TW{1'b0}};
      end else if (state_r == ST_WAIT) begin
        tcnt_r <= tcnt_r + TW'(1);
        if (!fft_ready) armed_r <= 1'b1;
      end
      if (capture_s) begin
        out_real_r <= fft_out_real;
        out_imag_r <= fft_out_imag;
        idx_r      <= 3'd0;
      end else if (beat_s) begin
        idx_r <= idx_r + 3'd1;
      end
      if (timeout_s) timeout_err_r <= 1'b1;
      if (beat_s && (idx_r == 3'd7)) frame_count_r <= frame_count_r + CNT_W'(1);
    end
  end

  assign s_ready     = (state_r == ST_FILL) && !RST;
  assign busy        = (state_r != ST_FILL);
  assign fft_write   = (state_r == ST_LOAD);
  assign fft_start   = (state_r == ST_START);
  assign fft_in_real = in_real_r;
  assign fft_in_imag = in_imag_r;
  assign m_valid     = (state_r == ST_UNLOAD);
  assign m_real      = m_valid ? out_real_r[int'(idx_r)*DW +: DW] : {DW{1'b0}};
  assign m_imag      = m_valid ? out_imag_r[int'(idx_r)*DW +: DW] : {DW{1'b0}};
  assign m_index     = m_valid ? idx_r : 3'd0;
  assign m_last      = m_valid && (idx_r == 3'd7);
  assign timeout_err = timeout_err_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a behavioural FFT core stand-in
// (outputs = inputs + 0x0010) and several ready-timing modes.
module tb_fft_frame_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [15:0]  s_real = 16'h0000;
  logic [15:0]  s_imag = 16'h0000;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [15:0]  m_real, m_imag;
  logic [2:0]   m_index;
  logic         m_last;
  logic         fft_write, fft_start;
  logic [127:0] fft_in_real, fft_in_imag;
  logic         fft_ready = 1'b0;
  logic [127:0] fft_out_real = 128'h0;
  logic [127:0] fft_out_imag = 128'h0;
  logic         busy, timeout_err;
  logic [15:0]  frame_count;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int core_mode = 0;   // 0 normal, 1 stale ready, 2 never ready
  int start_cyc = 0;
  int viol = 0;

  localparam logic [127:0] RAMP_RE = {16'h0700, 16'h0600, 16'h0500, 16'h0400,
                                      16'h0300, 16'h0200, 16'h0100, 16'h0000};
  localparam logic [127:0] RAMP_EXP = {16'h0710, 16'h0610, 16'h0510, 16'h0410,
                                       16'h0310, 16'h0210, 16'h0110, 16'h0010};
  localparam logic [127:0] ZERO128 = 128'h0;
  localparam logic [127:0] IM_EXP = {8{16'h0010}};

  fft_frame_ctrl #(.DW(16), .TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last),
    .fft_write(fft_write), .fft_start(fft_start),
    .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
    .fft_ready(fft_ready), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
    .busy(busy), .timeout_err(timeout_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] plus10(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = v[k*16 +: 16] + 16'h0010;
    return r;
  endfunction

  // Core stand-in: reacts to the start pulse, sampled mid-cycle
  always begin
    @(negedge clk);
    if (fft_start === 1'b1) begin
      start_cyc = cyc;
      fft_out_real = plus10(fft_in_real);
      fft_out_imag = plus10(fft_in_imag);
      if (core_mode == 0) begin
        fft_ready = 1'b0;
        repeat (10) @(negedge clk);
        fft_ready = 1'b1;
      end else if (core_mode == 1) begin
        fft_ready = 1'b1;
        repeat (4) @(negedge clk);
        fft_ready = 1'b0;
        repeat (2) @(negedge clk);
        fft_ready = 1'b1;
      end else begin
        fft_ready = 1'b0;
      end
    end
  end

  task automatic send_frame(input logic [127:0] re, input logic [127:0] im, input int gaps);
    int bound;
    for (int k = 0; k < 8; k++) begin
      if (gaps != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      s_valid = 1'b1;
      s_real  = re[k*16 +: 16];
      s_imag  = im[k*16 +: 16];
      bound = 0;
      while (s_ready !== 1'b1 && bound < 200) begin
        @(negedge clk);
        bound++;
      end
      if (bound >= 200) begin
        mismatched++;
        $display("FAIL send_timeout: beat %0d never accepted, s_ready=%b want 1", k, s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
    end
    compared++;
    if (fft_write !== 1'b1 || fft_start !== 1'b0) begin
      mismatched++;
      $display("FAIL write_pulse: write=%b start=%b, want 1 0", fft_write, fft_start);
    end
    @(negedge clk);
    compared++;
    if (fft_write !== 1'b0 || fft_start !== 1'b1) begin
      mismatched++;
      $display("FAIL start_pulse: write=%b start=%b, want 0 1", fft_write, fft_start);
    end
    @(negedge clk);
    compared++;
    if (fft_write !== 1'b0 || fft_start !== 1'b0 || fft_in_real[112 +: 16] !== re[112 +: 16]
        || fft_in_imag !== im) begin
      mismatched++;
      $display("FAIL core_inputs: write=%b start=%b in7=%h im=%h, want 0 0 %h %h",
               fft_write, fft_start, fft_in_real[112 +: 16], fft_in_imag, re[112 +: 16], im);
    end
  endtask

  task automatic recv_frame(input logic [127:0] er, input logic [127:0] ei,
                            input logic [3:0] pat, input int stop, output int first_cyc);
    int idx;
    int p;
    int bound;
    idx = 0; p = 0; bound = 0; first_cyc = -1;
    while (idx < stop && bound < 400) begin
      @(negedge clk);
      bound++;
      m_ready = pat[p % 4];
      p++;
      if (busy === 1'b1 && s_ready !== 1'b0) viol++;
      if (m_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        compared++;
        if (m_index !== idx[2:0] || m_real !== er[idx*16 +: 16] || m_imag !== ei[idx*16 +: 16]
            || m_last !== (idx == 7)) begin
          mismatched++;
          $display("FAIL bin%0d: idx=%0d re=%h im=%h last=%b, want idx=%0d re=%h im=%h last=%b",
                   idx, m_index, m_real, m_imag, m_last, idx, er[idx*16 +: 16],
                   ei[idx*16 +: 16], (idx == 7));
        end
        if (m_ready === 1'b1) idx++;
      end
    end
    if (idx < stop) begin
      mismatched++;
      $display("FAIL recv_timeout: got %0d bins, want %0d", idx, stop);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || fft_write !== 1'b0 || fft_start !== 1'b0
        || busy !== 1'b0 || timeout_err !== 1'b0 || frame_count !== 16'h0000
        || fft_in_real !== ZERO128 || m_real !== 16'h0000 || m_last !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b busy=%b terr=%b fc=%0d, want all 0",
               s_ready, m_valid, busy, timeout_err, frame_count);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release: s_ready=%b want 1", s_ready);
    end
  endtask

  task automatic test_ramp();
    int fc;
    core_mode = 0;
    send_frame(RAMP_RE, ZERO128, 0);
    recv_frame(RAMP_EXP, IM_EXP, 4'b1111, 8, fc);
    compared++;
    if (fc != start_cyc + 11) begin
      mismatched++;
      $display("FAIL ramp_latency: m_valid at %0d, want %0d", fc, start_cyc + 11);
    end
    @(negedge clk);
    compared++;
    if (frame_count !== 16'd1 || m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL ramp_count: fc=%0d m_valid=%b, want 1 0", frame_count, m_valid);
    end
  endtask

  task automatic test_backpressure();
    int fc;
    core_mode = 0;
    send_frame(RAMP_RE, ZERO128, 0);
    recv_frame(RAMP_EXP, IM_EXP, 4'b1001, 8, fc);
    @(negedge clk);
    compared++;
    if (frame_count !== 16'd2 || m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_count: fc=%0d m_valid=%b, want 2 0", frame_count, m_valid);
    end
  endtask

  task automatic test_stale_ready();
    int fc;
    core_mode = 1;
    send_frame(RAMP_RE, ZERO128, 0);
    recv_frame(RAMP_EXP, IM_EXP, 4'b1111, 8, fc);
    compared++;
    if (fc != start_cyc + 7) begin
      mismatched++;
      $display("FAIL stale_latency: m_valid at %0d, want %0d", fc, start_cyc + 7);
    end
    @(negedge clk);
    compared++;
    if (frame_count !== 16'd3) begin
      mismatched++;
      $display("FAIL stale_count: fc=%0d want 3", frame_count);
    end
  endtask

  task automatic test_timeout();
    int fc;
    int bound;
    int seen_valid;
    core_mode = 2;
    send_frame(RAMP_RE, ZERO128, 0);
    bound = 0; seen_valid = 0;
    while (cyc < start_cyc + 64 && bound < 200) begin
      @(negedge clk);
      bound++;
      if (m_valid === 1'b1) seen_valid++;
    end
    compared++;
    if (timeout_err !== 1'b0 || bound >= 200) begin
      mismatched++;
      $display("FAIL timeout_early: terr=%b at cycle %0d, want 0", timeout_err, cyc - start_cyc);
    end
    @(negedge clk);
    compared++;
    if (timeout_err !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_set: terr=%b s_ready=%b busy=%b, want 1 1 0",
               timeout_err, s_ready, busy);
    end
    compared++;
    if (seen_valid != 0 || frame_count !== 16'd3) begin
      mismatched++;
      $display("FAIL timeout_drop: valid cycles=%0d fc=%0d, want 0 3", seen_valid, frame_count);
    end
    core_mode = 0;
    send_frame(RAMP_RE, ZERO128, 0);
    recv_frame(RAMP_EXP, IM_EXP, 4'b1111, 8, fc);
    @(negedge clk);
    compared++;
    if (frame_count !== 16'd4 || timeout_err !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_recover: fc=%0d terr=%b, want 4 1", frame_count, timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int fc;
    core_mode = 0;
    send_frame(RAMP_RE, ZERO128, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0 || fft_in_real !== ZERO128 || fft_write !== 1'b0 || timeout_err !== 1'b0
        || frame_count !== 16'h0000 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_wait: busy=%b in=%h terr=%b fc=%0d s_ready=%b, want 0 0 0 0 1",
               busy, fft_in_real, timeout_err, frame_count, s_ready);
    end
    send_frame(RAMP_RE, ZERO128, 0);
    recv_frame(RAMP_EXP, IM_EXP, 4'b1111, 4, fc);
    @(negedge clk);
    compared++;
    if (m_index !== 3'd4 || m_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_unload_pre: idx=%0d valid=%b, want 4 1", m_index, m_valid);
    end
    m_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (m_valid !== 1'b0 || m_real !== 16'h0000 || m_imag !== 16'h0000 || m_index !== 3'd0
        || m_last !== 1'b0 || frame_count !== 16'h0000 || busy !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_unload: valid=%b re=%h idx=%0d fc=%0d s_ready=%b, want 0 0 0 0 1",
               m_valid, m_real, m_index, frame_count, s_ready);
    end
    send_frame(RAMP_RE, ZERO128, 0);
    recv_frame(RAMP_EXP, IM_EXP, 4'b1111, 8, fc);
    @(negedge clk);
    compared++;
    if (frame_count !== 16'd1) begin
      mismatched++;
      $display("FAIL rst_fresh: fc=%0d want 1", frame_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] re, im;
    int fc;
    core_mode = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    viol = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        re[k*16 +: 16] = 16'(k * 256 + f * 3 + 5);
        im[k*16 +: 16] = 16'(k * 32 + f * 7);
      end
      send_frame(re, im, 1);
      recv_frame(plus10(re), plus10(im), 4'b1011, 8, fc);
    end
    @(negedge clk);
    compared++;
    if (frame_count !== 16'd3 || viol != 0) begin
      mismatched++;
      $display("FAIL b2b: fc=%0d s_ready-while-busy=%0d, want 3 0", frame_count, viol);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_stale_ready();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
